// File: rtl/capture_sequencer.sv
// Capture sequencer: arms on host command, qualifies a synchronised trigger edge,
// strobes the capture buffer, tracks capture/accumulate handshakes per event,
// enforces a hold-off between events and hands the acquisition to the transmit path.
// Optional build macro CAPTURE_TIMEOUT_EN adds a watchdog on CAPTURE/ACCUM.
module capture_sequencer #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned HOLD_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [CNT_W-1:0]  num_events_i,
    input  logic [HOLD_W-1:0] holdoff_i,
    input  logic              trig_in_i,
    input  logic              trig_falling_i,
    input  logic              capture_done_i,
    input  logic              accum_done_i,
    input  logic              tx_ready_i,
    input  logic              tx_done_i,
    output logic              capture_strobe_o,
    output logic              tx_start_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  event_count_o,
    output logic              seq_error_o
);

    typedef enum logic [2:0] {
        StIdle, StArmed, StCapture, StAccum, StHoldoff, StTxWait, StTx
    } state_e;

    localparam logic [CNT_W-1:0] CountMax = '1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [HOLD_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic               strobe_q, strobe_d;
    logic               txs_q, txs_d;
    logic               s1_q, s2_q, s3_q;
    logic               trig_edge;
    logic               timeout;

    // Two-flop synchroniser plus a delay flop for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= trig_in_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign trig_edge = trig_falling_i ? (~s2_q & s3_q) : (s2_q & ~s3_q);

`ifdef CAPTURE_TIMEOUT_EN
    localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

    logic [WdogW-1:0] wdog_q, wdog_d;

    // Watchdog fires on the last cycle of the allowed CAPTURE/ACCUM residency.
    always_comb begin
        timeout = ((state_q == StCapture) || (state_q == StAccum)) && (wdog_q == WdogLast);
    end

    // Watchdog counts only while parked in CAPTURE/ACCUM; any state change clears it.
    always_comb begin
        wdog_d = '0;
        if ((state_d == state_q) && ((state_q == StCapture) || (state_q == StAccum))) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state, counters, error flag and output pulses.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        hold_d   = hold_q;
        hcnt_d   = hcnt_q;
        count_d  = count_q;
        err_d    = err_q;
        strobe_d = 1'b0;
        txs_d    = 1'b0;

        // Handshakes arriving in the wrong state are flagged but otherwise ignored.
        if ((capture_done_i && (state_q != StCapture)) ||
            (accum_done_i && (state_q != StAccum)) ||
            (tx_done_i && (state_q != StTx))) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (arm_i) begin
                    target_d = (num_events_i == '0) ? CNT_W'(1) : num_events_i;
                    hold_d   = holdoff_i;
                    count_d  = '0;
                    err_d    = 1'b0;
                    state_d  = StArmed;
                end
            end
            StArmed: begin
                if (trig_edge) begin
                    strobe_d = 1'b1;
                    state_d  = StCapture;
                end
            end
            StCapture: begin
                if (capture_done_i) state_d = StAccum;
            end
            StAccum: begin
                if (accum_done_i) begin
                    count_d = (count_q == CountMax) ? count_q : count_q + 1'b1;
                    if (count_d == target_q) begin
                        state_d = StTxWait;
                    end else if (hold_q == '0) begin
                        state_d = StArmed;
                    end else begin
                        hcnt_d  = hold_q;
                        state_d = StHoldoff;
                    end
                end
            end
            StHoldoff: begin
                if (hcnt_q <= HOLD_W'(1)) begin
                    state_d = StArmed;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            StTxWait: begin
                if (tx_ready_i) begin
                    txs_d   = 1'b1;
                    state_d = StTx;
                end
            end
            StTx: begin
                if (tx_done_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (timeout) begin
            err_d   = 1'b1;
            state_d = StIdle;
        end

        // Abort overrides everything: no pulses, no arm, error flag and count retained.
        if (abort_i) begin
            state_d  = StIdle;
            strobe_d = 1'b0;
            txs_d    = 1'b0;
            target_d = target_q;
            hold_d   = hold_q;
            count_d  = count_q;
            err_d    = err_q;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            target_q <= '0;
            hold_q   <= '0;
            hcnt_q   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            strobe_q <= 1'b0;
            txs_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            hold_q   <= hold_d;
            hcnt_q   <= hcnt_d;
            count_q  <= count_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
            txs_q    <= txs_d;
        end
    end

    assign capture_strobe_o = strobe_q;
    assign tx_start_o       = txs_q;
    assign busy_o           = (state_q != StIdle);
    assign event_count_o    = count_q;
    assign seq_error_o      = err_q;

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Single-clock controller that sequences multi-event acquisitions through the capture/accumulate/transmit FIFO chain.
- Arms on host command and qualifies an external trigger edge.
- Issues the one-cycle capture strobe into the fast capture buffer, then waits for buffer-full and accumulate-complete handshakes.
- Counts events up to a programmed total, enforces a hold-off between events, then hands off to the transmit path and waits for completion.

Parameters:
- CNT_W, 8, width of num_events and event_count.
- HOLD_W, 16, width of holdoff counter.
- TIMEOUT_CYCLES, 1000000, watchdog limit; used only with CAPTURE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted at 0); all state cleared immediately.
- arm  in  1  one-cycle pulse; starts an acquisition when IDLE; ignored otherwise.
- abort  in  1  level; forces IDLE next cycle from any state.
- num_events  in  CNT_W  events per acquisition; latched on accepted arm; 0 is treated as 1.
- holdoff  in  HOLD_W  idle cycles between events; latched on accepted arm.
- trig_in  in  1  raw asynchronous trigger.
- trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge; sampled live.
- capture_done  in  1  pulse; capture buffer reached almost-full.
- accum_done  in  1  pulse; event read into accumulator.
- tx_ready  in  1  level; transmit path can accept a frame.
- tx_done  in  1  pulse; transmit path drained.
- capture_strobe  out  1  one-cycle registered pulse to capture buffer.
- tx_start  out  1  one-cycle registered pulse to transmit path.
- busy  out  1  high in every state except IDLE.
- event_count  out  CNT_W  events completed in current acquisition.
- seq_error  out  1  sticky; cleared only on accepted arm or reset.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched registers 0.
- Trigger path:
  - Two-flop synchroniser, then a third flop for edge detection.
  - Edge = s2 & ~s3 when rising; ~s2 & s3 when falling.
  - capture_strobe is registered from the edge and rises on the 3rd posedge after trig_in changes.
- States (binary or one-hot, implementer's choice):
  - IDLE: on arm, latch num_events/holdoff, clear event_count and seq_error, go ARMED.
  - ARMED: on qualified edge, pulse capture_strobe and go CAPTURE. Edges in any other state are ignored (no strobe).
  - CAPTURE: on capture_done, go ACCUM.
  - ACCUM: on accum_done, event_count += 1.
    - If the new count equals the latched target, go TX_WAIT.
    - Else if holdoff == 0, go ARMED; else go HOLDOFF.
  - HOLDOFF: counter loads holdoff on entry and decrements each cycle; go ARMED the cycle after it reaches 1 (exactly holdoff cycles spent in HOLDOFF).
  - TX_WAIT: when tx_ready, pulse tx_start and go TX.
  - TX: on tx_done, go IDLE. event_count holds its final value until the next accepted arm.
- event_count saturates at the maximum value; no wrap.
- Protocol errors set seq_error and do not change state:
  - capture_done outside CAPTURE
  - accum_done outside ACCUM
  - tx_done outside TX
- Simultaneous arm and abort in IDLE: abort wins; arm is ignored.
- abort in any state:
  - next state IDLE
  - no strobe or tx_start issued that cycle
  - event_count retained
  - seq_error unchanged
- Reset mid-operation: asynchronous return to IDLE; pending pulses are dropped.

Optional Feature:
- Macro: CAPTURE_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in CAPTURE and ACCUM and clears on every state change.
  - Reaching TIMEOUT_CYCLES sets seq_error and forces IDLE.
- Undefined:
  - No watchdog logic.
  - CAPTURE and ACCUM wait indefinitely.
  - seq_error reflects protocol errors only.

Test Plan:
1. Reset low, then high; arm with num_events=1, holdoff=0; rising trig_in; capture_done; accum_done; tx_ready=1; tx_done → exactly one capture_strobe (3 cycles after trig_in), one tx_start, event_count=1, busy low after tx_done.
2. num_events=3, holdoff=5; three triggers with handshakes → 3 strobes, at least 5 cycles between accum_done and re-arm, event_count=3, then tx_start.
3. trig_in toggles while in CAPTURE and HOLDOFF → no extra capture_strobe; capture_done pulsed in ARMED → seq_error=1, state unchanged.
4. Abort asserted in CAPTURE with event_count=1 → IDLE next cycle, busy=0, event_count=1. A subsequent arm clears event_count and seq_error to 0.
5. num_events=0 → behaves as 1; trig_falling=1 → strobe only on the 1→0 transition.
6. With CAPTURE_TIMEOUT_EN and TIMEOUT_CYCLES=100: trigger, never pulse capture_done → seq_error=1 and IDLE after 100 cycles in CAPTURE. Without the macro: still CAPTURE after 200 cycles.
